spu_mul_seq: RTL and testbench

//  SPU-side initiator for the shared multiplier datapath. Accepts one command at a time

---
 rtl/spu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_spu_mul_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_mul_seq.sv
// SPU-side sequencer for the shared multiplier: one command in flight,
// arbitrated request, fixed-latency wait, registered 64-bit result.
module spu_mul_seq #(
    parameter int MUL_LAT = 5
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_x2,
    input  logic [63:0] cmd_op1,
    input  logic [63:0] cmd_op2,
    output logic        spu_mul_req,
    input  logic        mul_spu_ack,
    output logic [63:0] spu_mul_op1_data,
    output logic [63:0] spu_mul_op2_data,
    output logic        x2,
    output logic        byp_sel,
    output logic        byp_imm,
    output logic        acc_imm,
    output logic        acc_actc2,
    output logic        acc_actc5,
    output logic        acc_actc3,
    output logic        acc_reg_enb,
    output logic        acc_reg_rst,
    output logic        acc_reg_shf,
    input  logic [63:0] mul_data_out,
    output logic        res_vld,
    input  logic        res_rdy,
    output logic [63:0] res_data
);

    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MAC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_RDHI = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CLR,
        SHF,
        WAIT,
        CAP,
        DONE
    } state_t;

    state_t         state;
    logic [1:0]     op_q;
    logic [CW-1:0]  cnt;

    assign byp_sel   = 1'b0;
    assign byp_imm   = 1'b0;
    assign acc_imm   = 1'b0;
    assign acc_actc2 = 1'b0;
    assign acc_actc5 = 1'b0;

    always_ff @(posedge rclk) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= OP_MUL;
            cnt              <= '0;
            cmd_rdy          <= 1'b1;
            spu_mul_req      <= 1'b0;
            spu_mul_op1_data <= '0;
            spu_mul_op2_data <= '0;
            x2               <= 1'b0;
            acc_actc3        <= 1'b0;
            acc_reg_enb      <= 1'b0;
            acc_reg_rst      <= 1'b0;
            acc_reg_shf      <= 1'b0;
            res_vld          <= 1'b0;
            res_data         <= '0;
        end else begin
            acc_reg_enb <= 1'b0;
            acc_reg_rst <= 1'b0;
            acc_reg_shf <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy) begin
                        cmd_rdy          <= 1'b0;
                        op_q             <= cmd_op;
                        x2               <= cmd_x2 & ~cmd_op[1];
                        spu_mul_op1_data <= cmd_op1;
                        spu_mul_op2_data <= cmd_op2;
                        unique case (cmd_op)
                            OP_CLR: begin
                                state       <= CLR;
                                acc_reg_rst <= 1'b1;
                            end
                            OP_RDHI: begin
                                state       <= SHF;
                                acc_reg_shf <= 1'b1;
                                acc_reg_enb <= 1'b1;
                            end
                            OP_MUL, OP_MAC: begin
                                state       <= REQ;
                                spu_mul_req <= 1'b1;
                                acc_actc3   <= (cmd_op == OP_MAC);
                            end
                        endcase
                    end
                end
                REQ: begin
                    if (mul_spu_ack) begin
                        spu_mul_req <= 1'b0;
                        cnt         <= CW'(MUL_LAT - 1);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter hits zero on the cycle the product is presented.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= CAP;
                        acc_reg_enb <= (op_q == OP_MAC);
                    end
                end
                CAP: begin
                    res_data  <= mul_data_out;
                    acc_actc3 <= 1'b0;
                    res_vld   <= 1'b1;
                    state     <= DONE;
                end
                CLR: begin
                    res_data <= '0;
                    res_vld  <= 1'b1;
                    state    <= DONE;
                end
                SHF: begin
                    state <= CAP;
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        cmd_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_mul_seq.sv
// Bench for spu_mul_seq: a multiplier/accumulator emulation plus a
// plain-arithmetic accumulator reference for expected results.
module tb_spu_mul_seq;

    localparam int MUL_LAT = 5;

    logic        rclk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [1:0]  cmd_op;
    logic        cmd_x2;
    logic [63:0] cmd_op1;
    logic [63:0] cmd_op2;
    logic        spu_mul_req;
    logic        mul_spu_ack;
    logic [63:0] spu_mul_op1_data;
    logic [63:0] spu_mul_op2_data;
    logic        x2;
    logic        byp_sel;
    logic        byp_imm;
    logic        acc_imm;
    logic        acc_actc2;
    logic        acc_actc5;
    logic        acc_actc3;
    logic        acc_reg_enb;
    logic        acc_reg_rst;
    logic        acc_reg_shf;
    logic [63:0] mul_data_out = '0;
    logic        res_vld;
    logic        res_rdy;
    logic [63:0] res_data;

    int errs = 0;
    int checks = 0;

    logic [127:0] racc = '0;
    logic [127:0] macc = '0;
    logic [127:0] pfull = '0;
    logic [127:0] emu_cur;
    logic [127:0] emu_nacc;
    bit           pend = 0;
    longint       ncyc = 0;
    longint       due = 0;

    always #5 rclk = ~rclk;

    spu_mul_seq #(.MUL_LAT(MUL_LAT)) dut (
        .rclk(rclk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_x2(cmd_x2), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .spu_mul_req(spu_mul_req), .mul_spu_ack(mul_spu_ack),
        .spu_mul_op1_data(spu_mul_op1_data),
        .spu_mul_op2_data(spu_mul_op2_data), .x2(x2),
        .byp_sel(byp_sel), .byp_imm(byp_imm), .acc_imm(acc_imm),
        .acc_actc2(acc_actc2), .acc_actc5(acc_actc5),
        .acc_actc3(acc_actc3), .acc_reg_enb(acc_reg_enb),
        .acc_reg_rst(acc_reg_rst), .acc_reg_shf(acc_reg_shf),
        .mul_data_out(mul_data_out), .res_vld(res_vld),
        .res_rdy(res_rdy), .res_data(res_data)
    );

    // Multiplier + 128-bit accumulator emulation, evaluated mid-cycle.
    initial forever begin
        @(negedge rclk);
        ncyc++;
        emu_cur = (pend && due == ncyc) ? pfull : macc;
        mul_data_out = emu_cur[63:0];
        emu_nacc = macc;
        if (acc_reg_rst) emu_nacc = '0;
        else if (acc_reg_shf && acc_reg_enb) emu_nacc = macc >> 64;
        else if (acc_reg_enb) emu_nacc = emu_cur;
        if (spu_mul_req && mul_spu_ack) begin
            pend = 1;
            due = ncyc + MUL_LAT;
            pfull = (acc_actc3 ? macc : 128'd0)
                  + 128'(spu_mul_op1_data) * 128'(spu_mul_op2_data)
                  * (x2 ? 128'd2 : 128'd1);
        end
        macc = emu_nacc;
    end

    task automatic run_cmd(input string nm, input logic [1:0] op,
                           input logic dbl, input logic [63:0] a,
                           input logic [63:0] b, input int ack_dly,
                           input int hold);
        logic [127:0] p;
        logic [63:0]  exp;
        int k, gk, vk, rq, enb_n, rst_n, shf_n, act_w, act_t;
        int strb, strb_exp, lat, lat_exp, rdy_done;
        bit granted, op_bad, req_bad, stall_bad;
        p = 128'(a) * 128'(b) * (dbl ? 128'd2 : 128'd1);
        case (op)
            2'd0: exp = p[63:0];
            2'd1: begin racc = racc + p; exp = racc[63:0]; end
            2'd2: begin racc = '0; exp = '0; end
            default: begin racc = racc >> 64; exp = racc[63:0]; end
        endcase
        gk = -1; vk = -1; rq = 0; granted = 0; op_bad = 0; req_bad = 0;
        enb_n = 0; rst_n = 0; shf_n = 0; act_w = 0; act_t = 0;
        stall_bad = 0; rdy_done = 1;
        @(posedge rclk); #1;
        cmd_vld = 1; cmd_op = op; cmd_x2 = dbl; cmd_op1 = a; cmd_op2 = b;
        k = 0;
        while (cmd_rdy !== 1'b1 && k < 50) begin
            @(posedge rclk); #1; k++;
        end
        @(posedge rclk); #1;
        cmd_vld = 0; cmd_op = 2'($urandom); cmd_x2 = 1'($urandom);
        cmd_op1 = {$urandom, $urandom}; cmd_op2 = {$urandom, $urandom};
        for (int c = 1; c <= 40; c++) begin
            if (res_vld === 1'b1) begin
                vk = c;
                rdy_done = int'(cmd_rdy);
                break;
            end
            if (spu_mul_req === 1'b1) begin
                if (spu_mul_op1_data !== a || spu_mul_op2_data !== b ||
                    x2 !== dbl) op_bad = 1;
                if (granted) req_bad = 1;
            end
            mul_spu_ack = 0;
            if (spu_mul_req === 1'b1 && !granted) begin
                if (rq == ack_dly) begin
                    mul_spu_ack = 1; granted = 1; gk = c;
                end else rq++;
            end
            enb_n += int'(acc_reg_enb);
            rst_n += int'(acc_reg_rst);
            shf_n += int'(acc_reg_shf);
            act_t += int'(acc_actc3);
            if (granted) act_w += int'(acc_actc3);
            @(posedge rclk); #1;
        end
        mul_spu_ack = 0;
        lat = (op[1] == 1'b0) ? vk - gk : vk;
        lat_exp = (op[1] == 1'b0) ? MUL_LAT + 1 : (op == 2'd2 ? 2 : 3);
        checks++;
        if (vk < 0 || (op[1] == 1'b0 && gk < 0) || lat !== lat_exp) begin
            errs++;
            $display("FAIL %s/latency: got %0d (vk=%0d gk=%0d) want %0d",
                     nm, lat, vk, gk, lat_exp);
        end
        checks++;
        if (res_data !== exp) begin
            errs++;
            $display("FAIL %s/res_data: got %h want %h", nm, res_data, exp);
        end
        checks++;
        if (op_bad || req_bad || (op[1] == 1'b1 && granted)) begin
            errs++;
            $display("FAIL %s/request: op_bad=%0d req_bad=%0d granted=%0d want 0/0/%0d",
                     nm, op_bad, req_bad, granted, int'(op[1] == 1'b0));
        end
        strb = enb_n * 100 + rst_n * 10 + shf_n;
        case (op)
            2'd0: strb_exp = 0;
            2'd1: strb_exp = 100;
            2'd2: strb_exp = 10;
            default: strb_exp = 101;
        endcase
        checks++;
        if (strb !== strb_exp) begin
            errs++;
            $display("FAIL %s/strobes(enb,rst,shf): got %03d want %03d",
                     nm, strb, strb_exp);
        end
        checks++;
        if (op == 2'd1 ? act_w !== MUL_LAT + 1 : act_t !== 0) begin
            errs++;
            $display("FAIL %s/actc3: got win=%0d tot=%0d want %0d",
                     nm, act_w, act_t, op == 2'd1 ? MUL_LAT + 1 : 0);
        end
        checks++;
        if (rdy_done !== 0) begin
            errs++;
            $display("FAIL %s/cmd_rdy_in_done: got %0d want 0", nm, rdy_done);
        end
        for (int h = 0; h < hold; h++) begin
            res_rdy = 0; cmd_vld = 1; cmd_op = 2'($urandom);
            cmd_op1 = {$urandom, $urandom};
            @(posedge rclk); #1;
            if (res_vld !== 1'b1 || res_data !== exp || cmd_rdy !== 1'b0 ||
                spu_mul_req !== 1'b0) stall_bad = 1;
        end
        if (hold > 0) begin
            checks++;
            if (stall_bad) begin
                errs++;
                $display("FAIL %s/stall: got vld=%b data=%h rdy=%b req=%b want 1/%h/0/0",
                         nm, res_vld, res_data, cmd_rdy, spu_mul_req, exp);
            end
        end
        res_rdy = 1;
        @(posedge rclk); #1;
        res_rdy = 0; cmd_vld = 0;
        checks++;
        if (cmd_rdy !== 1'b1 || res_vld !== 1'b0) begin
            errs++;
            $display("FAIL %s/handoff: got rdy=%b vld=%b want 1/0",
                     nm, cmd_rdy, res_vld);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge rclk);
        #1;
        checks++;
        if (cmd_rdy !== 1'b1) begin
            errs++;
            $display("FAIL reset/cmd_rdy: got %b want 1", cmd_rdy);
        end
        checks++;
        if ({spu_mul_req, res_vld, x2} !== 3'b000) begin
            errs++;
            $display("FAIL reset/req_vld_x2: got %b want 000",
                     {spu_mul_req, res_vld, x2});
        end
        checks++;
        if ({acc_actc3, acc_reg_enb, acc_reg_rst, acc_reg_shf, byp_sel,
             byp_imm, acc_imm, acc_actc2, acc_actc5} !== 9'd0) begin
            errs++;
            $display("FAIL reset/acc_ctl: got %b want 0",
                     {acc_actc3, acc_reg_enb, acc_reg_rst, acc_reg_shf,
                      byp_sel, byp_imm, acc_imm, acc_actc2, acc_actc5});
        end
        checks++;
        if (res_data !== 64'd0 || spu_mul_op1_data !== 64'd0 ||
            spu_mul_op2_data !== 64'd0) begin
            errs++;
            $display("FAIL reset/data: got res=%h op1=%h op2=%h want 0",
                     res_data, spu_mul_op1_data, spu_mul_op2_data);
        end
        rst = 0;
    endtask

    task automatic test_mul();
        run_cmd("mul_3x7", 2'd0, 1'b0, 64'd3, 64'd7, 2, 0);
    endtask

    task automatic test_mul_x2();
        run_cmd("mul_x2", 2'd0, 1'b1, 64'hFFFF_FFFF, 64'd2, 0, 1);
    endtask

    task automatic test_mac();
        run_cmd("clr", 2'd2, 1'b0, 64'd0, 64'd0, 0, 0);
        run_cmd("mac_5x6", 2'd1, 1'b0, 64'd5, 64'd6, 1, 0);
        run_cmd("mac_2x4", 2'd1, 1'b0, 64'd2, 64'd4, 3, 0);
    endtask

    task automatic test_rdhi();
        run_cmd("mac_big", 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h1234_5678_9ABC_DEF0, 0, 0);
        run_cmd("rdhi", 2'd3, 1'b0, 64'd0, 64'd0, 0, 2);
    endtask

    task automatic test_stall();
        run_cmd("stall10", 2'd0, 1'b0, 64'h0123_4567, 64'h89AB, 1, 10);
    endtask

    task automatic test_rst_mid_mac();
        int enb_seen;
        enb_seen = 0;
        @(posedge rclk); #1;
        cmd_vld = 1; cmd_op = 2'd1; cmd_x2 = 0;
        cmd_op1 = 64'd1000; cmd_op2 = 64'd1000;
        @(posedge rclk); #1;
        cmd_vld = 0; mul_spu_ack = 1;
        @(posedge rclk); #1;
        mul_spu_ack = 0;
        @(posedge rclk); #1;
        rst = 1;
        @(posedge rclk); #1;
        rst = 0;
        checks++;
        if (cmd_rdy !== 1'b1 || res_vld !== 1'b0 || acc_actc3 !== 1'b0 ||
            spu_mul_req !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid/state: got rdy=%b vld=%b actc3=%b req=%b want 1/0/0/0",
                     cmd_rdy, res_vld, acc_actc3, spu_mul_req);
        end
        for (int i = 0; i < MUL_LAT + 4; i++) begin
            enb_seen += int'(acc_reg_enb) + int'(res_vld);
            @(posedge rclk); #1;
        end
        checks++;
        if (enb_seen !== 0) begin
            errs++;
            $display("FAIL rst_mid/no_enb: got %0d want 0", enb_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [63:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom);
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                            : 64'($urandom_range(0, 255));
            run_cmd($sformatf("rnd%0d", i), op, 1'($urandom), a, b,
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1; cmd_vld = 0; cmd_op = 0; cmd_x2 = 0;
        cmd_op1 = 0; cmd_op2 = 0; mul_spu_ack = 0; res_rdy = 0;
        test_reset();
        test_mul();
        test_mul_x2();
        test_mac();
        test_rdhi();
        test_stall();
        test_rst_mid_mac();
        run_cmd("mac_after_rst", 2'd1, 1'b0, 64'd3, 64'd3, 0, 0);
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
